// File: rtl/bcd_display_scan_if.sv
// Digit inputs and display outputs of the BCD scan driver, bundled for port hookup.
// master = digit source / board side, slave = the scan driver itself.
interface bcd_display_scan_if;
    logic [4:0] Pnum;
    logic [4:0] Snum;
    logic [4:0] Tnum;
    logic       en;
    logic       blank_lz;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output Pnum, Snum, Tnum, en, blank_lz,
        input  an, seg, dp
    );

    modport slave (
        input  Pnum, Snum, Tnum, en, blank_lz,
        output an, seg, dp
    );
endinterface

// File: rtl/bcd_display_scan.sv
// Time-multiplexed 3-digit common-anode 7-segment scanner with per-frame input snapshot,
// leading-zero blanking, dash for invalid digits and a display enable.
module bcd_display_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 16
) (
    input logic               clk,
    input logic               rst_n,
    bcd_display_scan_if.slave bus
);

    typedef enum logic [1:0] {
        SEL_UNITS = 2'd0,
        SEL_TENS  = 2'd1,
        SEL_HUNDS = 2'd2
    } sel_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    sel_e             sel_q, sel_d;
    logic [4:0]       hund_q, hund_d, tens_q, tens_d, units_q, units_d;
    logic [3:0]       an_q, an_d, an_sel;
    logic [6:0]       seg_q, seg_d;
    logic [4:0]       digit;
    logic             blank;
    logic             tick;

    function automatic logic [6:0] decode(input logic [4:0] d);
        case (d)
            5'd0:    decode = 7'b1000000;
            5'd1:    decode = 7'b1111001;
            5'd2:    decode = 7'b0100100;
            5'd3:    decode = 7'b0110000;
            5'd4:    decode = 7'b0011001;
            5'd5:    decode = 7'b0010010;
            5'd6:    decode = 7'b0000010;
            5'd7:    decode = 7'b1111000;
            5'd8:    decode = 7'b0000000;
            5'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
        sel_d   = sel_q;
        hund_d  = hund_q;
        tens_d  = tens_q;
        units_d = units_q;
        an_d    = an_q;
        seg_d   = seg_q;
        an_sel  = 4'b1111;
        digit   = '0;
        blank   = 1'b0;

        if (tick) begin
            case (sel_q)
                SEL_UNITS: sel_d = SEL_TENS;
                SEL_TENS:  sel_d = SEL_HUNDS;
                default: begin
                    sel_d   = SEL_UNITS;
                    hund_d  = bus.Pnum;
                    tens_d  = bus.Snum;
                    units_d = bus.Tnum;
                end
            endcase

            // Outputs follow the new select, so the units slot sees the freshly loaded snapshot.
            case (sel_d)
                SEL_UNITS: begin
                    digit  = units_d;
                    an_sel = 4'b1110;
                end
                SEL_TENS: begin
                    digit  = tens_d;
                    blank  = bus.blank_lz && (hund_d == 5'd0) && (tens_d == 5'd0);
                    an_sel = 4'b1101;
                end
                default: begin
                    digit  = hund_d;
                    blank  = bus.blank_lz && (hund_d == 5'd0);
                    an_sel = 4'b1011;
                end
            endcase

            seg_d = blank ? 7'b1111111 : decode(digit);
            an_d  = bus.en ? an_sel : 4'b1111;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            sel_q   <= SEL_HUNDS;
            // NOTE: the snapshot is a handful of flops, not a RAM, so it is reset; blanking then never sees stale digits.
            hund_q  <= '0;
            tens_q  <= '0;
            units_q <= '0;
            an_q    <= 4'b1111;
            seg_q   <= 7'b1111111;
        end else begin
            // NOTE: non-blocking updates make all registers take their _d values together at the edge.
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            hund_q  <= hund_d;
            tens_q  <= tens_d;
            units_q <= units_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = 1'b1;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench for bcd_display_scan: directed scan/blanking/enable/reset cases plus
// randomized inputs checked every cycle against a frame-arithmetic reference model.
module tb_bcd_display_scan;

    localparam int DIV = 4;

    logic clk;
    logic rst_n;
    bcd_display_scan_if bus ();

    bcd_display_scan #(.REFRESH_DIV(DIV), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    // Reference model: k = edges since reset released; every DIV-th edge starts a new
    // slot, slots cycle units/tens/hundreds, and a units slot starts a new frame.
    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    int         k;
    logic [4:0] m_h, m_t, m_u;
    logic [3:0] m_an;
    logic [6:0] m_seg;
    bit         chk_on = 1'b0;

    always @(posedge clk) begin
        int         pos;
        logic [4:0] d;
        logic [3:0] onehot;
        bit         blank;
        if (!rst_n) begin
            k = 0; m_h = 0; m_t = 0; m_u = 0;
            m_an = 4'b1111; m_seg = 7'b1111111;
        end else begin
            k++;
            if (k % DIV == 0) begin
                pos = ((k / DIV) - 1) % 3;
                if (pos == 0) begin
                    m_h = bus.Pnum; m_t = bus.Snum; m_u = bus.Tnum;
                end
                d = (pos == 0) ? m_u : (pos == 1) ? m_t : m_h;
                blank = bus.blank_lz && ((pos == 2 && m_h == 0) || (pos == 1 && m_h == 0 && m_t == 0));
                m_seg = blank ? 7'b1111111 : (d > 9) ? 7'b0111111 : seg_tab[d];
                onehot = 4'b0001 << pos;
                m_an = bus.en ? ~onehot : 4'b1111;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_an", 8'(bus.an), 8'(m_an));
            check("model_seg", 8'(bus.seg), 8'(m_seg));
            check("dp", 8'(bus.dp), 8'd1);
        end
    end

    task automatic set_digits(input int p, input int s, input int t, input bit bl);
        bus.Pnum = 5'(p); bus.Snum = 5'(s); bus.Tnum = 5'(t); bus.blank_lz = bl;
    endtask

    // Advance to the first negedge of a units slot that follows a non-units slot.
    task automatic wait_frame();
        logic [3:0] prev;
        bit found = 1'b0;
        prev = bus.an;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (bus.an == 4'b1110 && prev != 4'b1110) found = 1'b1;
            prev = bus.an;
        end
        check("frame_sync", 8'(found), 8'd1);
    endtask

    task automatic slot_check(input string tag, input logic [3:0] an_e, input logic [6:0] seg_e);
        check({tag, "_an"}, 8'(bus.an), 8'(an_e));
        check({tag, "_seg"}, 8'(bus.seg), 8'(seg_e));
    endtask

    task automatic reset_release_check(input string tag);
        check({tag, "_an0"}, 8'(bus.an), 8'hF);
        check({tag, "_seg0"}, 8'(bus.seg), 8'h7F);
        repeat (3) begin
            @(negedge clk);
            check({tag, "_an_dark"}, 8'(bus.an), 8'hF);
        end
        @(negedge clk);
    endtask

    function automatic logic [4:0] rand_digit();
        case ($urandom_range(0, 3))
            0:       rand_digit = 5'd0;
            3:       rand_digit = 5'($urandom_range(0, 31));
            default: rand_digit = 5'($urandom_range(0, 9));
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        bus.en = 1'b1;
        set_digits(0, 0, 1, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_on = 1'b1;
        rst_n  = 1'b1;
        reset_release_check("rst");
        slot_check("first_units", 4'b1110, 7'b1111001);

        set_digits(1, 2, 5, 1'b0);
        wait_frame();
        slot_check("seq_units", 4'b1110, 7'b0010010);
        repeat (2) @(negedge clk);
        slot_check("seq_units_hold", 4'b1110, 7'b0010010);
        repeat (2) @(negedge clk);
        slot_check("seq_tens", 4'b1101, 7'b0100100);
        repeat (4) @(negedge clk);
        slot_check("seq_hunds", 4'b1011, 7'b1111001);

        set_digits(0, 0, 7, 1'b1);
        wait_frame();
        slot_check("blz_units", 4'b1110, 7'b1111000);
        repeat (4) @(negedge clk);
        slot_check("blz_tens", 4'b1101, 7'b1111111);
        repeat (4) @(negedge clk);
        slot_check("blz_hunds", 4'b1011, 7'b1111111);

        bus.blank_lz = 1'b0;
        wait_frame();
        repeat (4) @(negedge clk);
        slot_check("noblz_tens", 4'b1101, 7'b1000000);
        repeat (4) @(negedge clk);
        slot_check("noblz_hunds", 4'b1011, 7'b1000000);

        set_digits(0, 12, 4, 1'b1);
        wait_frame();
        repeat (4) @(negedge clk);
        slot_check("dash_tens", 4'b1101, 7'b0111111);
        repeat (4) @(negedge clk);
        slot_check("dash_hunds_blank", 4'b1011, 7'b1111111);

        set_digits(3, 20, 9, 1'b0);
        wait_frame();
        repeat (4) @(negedge clk);
        slot_check("bit4_tens", 4'b1101, 7'b0111111);

        // Snapshot isolation: change units mid-frame, display must not tear.
        set_digits(0, 0, 3, 1'b0);
        wait_frame();
        bus.Tnum = 5'd8;
        @(negedge clk);
        slot_check("snap_hold_units", 4'b1110, 7'b0110000);
        wait_frame();
        slot_check("snap_new_units", 4'b1110, 7'b0000000);

        // Reset pulse while tens slot is mid-count.
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        reset_release_check("midrst");
        slot_check("midrst_units", 4'b1110, 7'b0000000);

        // Display off for one frame, then back in phase.
        wait_frame();
        bus.en = 1'b0;
        repeat (4) @(negedge clk);
        check("en_off_tens", 8'(bus.an), 8'hF);
        repeat (4) @(negedge clk);
        check("en_off_hunds", 8'(bus.an), 8'hF);
        bus.en = 1'b1;
        repeat (4) @(negedge clk);
        check("en_on_units", 8'(bus.an), 8'b1110);

        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) bus.Pnum = rand_digit();
            if ($urandom_range(0, 5) == 0) bus.Snum = rand_digit();
            if ($urandom_range(0, 5) == 0) bus.Tnum = rand_digit();
            if ($urandom_range(0, 39) == 0) bus.blank_lz = ~bus.blank_lz;
            if ($urandom_range(0, 59) == 0) bus.en = ~bus.en;
            rst_n = ($urandom_range(0, 249) != 0);
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
